seq_gen_tx: RTL
===============

# seq_gen_tx

Bit-serial frame transmitter that drives the line consumed by the team's 1011 Moore sequence detector. It accepts parallel payload words over a valid/ready handshake. For each word it emits one frame: the 4-bit sync pattern 1011, then the payload MSB-first, then an optional even-parity bit, then a run of idle zeros. It sits at the source end of the serial link, and a detector on the far end flags each frame start.

## Interface
- DATA_W, 8: payload bits per frame; legal range 1..32.
- GAP_BITS, 2: idle zero bits after each frame; legal range 2..15. Two zeros return the detector to its idle state from any state.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  payload word available.
- in_data  in  DATA_W  payload word; sampled only on handshake.
- in_ready  out  1  transmitter can accept a word this cycle.
- out  out  1  serial line, registered.
- busy  out  1  frame in progress (SYNC, DATA, PAR or GAP).
- tx_done  out  1  one-cycle pulse marking the last gap bit of a frame.

## Operation
- A handshake occurs on a rising edge where in_valid=1 and in_ready=1. in_data is latched into the shift register on that edge.
- States and transitions:
  - IDLE: out=0. Handshake -> SYNC.
  - SYNC: four cycles; out = 1, 0, 1, 1 in that order. Then -> DATA.
  - DATA: DATA_W cycles; out = shift_reg MSB first. Then -> PAR if SEQ_TX_PARITY_EN is defined, else -> GAP.
  - PAR: one cycle; out = XOR of all latched payload bits (even parity). Then -> GAP.
  - GAP: GAP_BITS cycles; out=0. On the last gap cycle, handshake -> SYNC, otherwise -> IDLE.
- Counters:
  - Bit counter is ceil(log2(max(DATA_W, GAP_BITS, 4)))+1 bits wide.
  - It reloads on each state entry and counts down to 0.
  - There is no wrap-around inside a state.
- Handshake rules:
  - in_ready=1 in IDLE and on the last GAP cycle only; 0 in all other states.
  - in_valid held high while busy causes no acceptance and no data change.
- in_data changes outside the handshake edge have no effect on the frame in flight.
- tx_done is high on the last GAP cycle, including when a back-to-back handshake occurs on that same cycle.
- busy=1 in SYNC, DATA, PAR and GAP.

## Timing
- Reset (rst=0), applied asynchronously, including mid-frame:
  - state=IDLE, out=0, busy=0, tx_done=0, in_ready=0.
  - Any partially sent word is discarded; no truncation marker is sent.
- in_ready rises on the first rising edge after rst deasserts.
- Handshake on edge T:
  - First sync bit on out during cycle T+1.
  - Payload MSB at T+5.
  - Payload LSB at T+4+DATA_W.
- Frame length L = 4 + DATA_W + P + GAP_BITS cycles, where P=1 with parity, else 0.
- Back-to-back throughput is one word per L cycles with no extra idle cycle.
- A detector sampling on the same clock asserts its output in the cycle after the 4th sync bit is on out.
- out is glitch-free: it is driven directly from a flop.

## Configuration
- SEQ_TX_PARITY_EN defined:
  - PAR state is present; frame carries one even-parity bit after the LSB.
  - L includes +1.
- SEQ_TX_PARITY_EN undefined:
  - PAR state and parity logic are removed; DATA -> GAP directly.
  - L = 4 + DATA_W + GAP_BITS.

## Test plan
- Single word, defaults, parity enabled: handshake 0xA5 at T -> out from T+1 = 1011 10100101 0 00. busy high for 15 cycles; tx_done at T+15; in_ready high at T+15.
- Back-to-back: in_valid held high with 0xFF then 0x00 -> second frame sync starts the cycle after the first frame's last gap bit. Stream = 1011 11111111 0 00 1011 00000000 0 00.
- Stall: in_valid=1 during DATA with a different in_data -> no second handshake, and the first frame's payload is unchanged.
- Reset mid-DATA: rst=0 after the 3rd payload bit -> out=0 and busy=0 immediately. in_ready=0 until the first edge after release, then the next frame is complete and correct.
- Parity compiled out, word 0x0F -> out = 1011 00001111 00; L=14.
- Loopback: drive out into the 1011 Moore detector for 20 random words -> at least 20 detector pulses, one per frame at sync bit 4 + 1 cycle. The detector is in its idle state after every gap.

Source files
------------

// File: rtl/seq_gen_tx.sv
// Bit-serial frame transmitter: sync 1011, payload MSB-first, optional even parity, idle gap.
// Optional parity bit is compiled in when SEQ_TX_PARITY_EN is defined.
module seq_gen_tx #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out,
    output logic              busy,
    output logic              tx_done
);

    localparam int unsigned MAX_DG  = (DATA_W > GAP_BITS) ? DATA_W : GAP_BITS;
    localparam int unsigned MAX_LEN = (MAX_DG > 4) ? MAX_DG : 4;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;
    localparam logic [3:0]  SYNC_PAT = 4'b1011;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StData,
`ifdef SEQ_TX_PARITY_EN
        StPar,
`endif
        StGap
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               out_q, out_d;
    logic               init_q;
    logic               last_gap;
    logic               hs;
`ifdef SEQ_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    assign last_gap = (state_q == StGap) && (cnt_q == '0);
    // init_q holds in_ready low until the first edge after reset release
    assign in_ready = ((state_q == StIdle) && init_q) || last_gap;
    assign busy     = (state_q != StIdle);
    assign tx_done  = last_gap;
    assign out      = out_q;
    assign hs       = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        out_d   = 1'b0;
`ifdef SEQ_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            StIdle: ;
            StSync: begin
                if (cnt_q == '0) begin
                    state_d = StData;
                    cnt_d   = CNT_W'(DATA_W - 1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StData: begin
                shreg_d = shreg_q << 1;
                if (cnt_q == '0) begin
`ifdef SEQ_TX_PARITY_EN
                    state_d = StPar;
                    cnt_d   = '0;
`else
                    state_d = StGap;
                    cnt_d   = CNT_W'(GAP_BITS - 1);
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef SEQ_TX_PARITY_EN
            StPar: begin
                state_d = StGap;
                cnt_d   = CNT_W'(GAP_BITS - 1);
            end
`endif
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Only possible in idle or on the last gap bit, so it overrides both
        if (hs) begin
            state_d = StSync;
            cnt_d   = CNT_W'(3);
            shreg_d = in_data;
`ifdef SEQ_TX_PARITY_EN
            par_d   = ^in_data;
`endif
        end

        // Line value for the next cycle, so out comes straight from a flop
        case (state_d)
            StSync:  out_d = SYNC_PAT[cnt_d[1:0]];
            StData:  out_d = shreg_d[DATA_W-1];
`ifdef SEQ_TX_PARITY_EN
            StPar:   out_d = par_d;
`endif
            default: out_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            shreg_q <= '0;
            out_q   <= 1'b0;
            init_q  <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            out_q   <= out_d;
            init_q  <= 1'b1;
`ifdef SEQ_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
